adder_sum_decomposer: RTL and testbench

//   Reverse end of the registered wide adder benchmark: given a (WIDTH+1)-bit sum
//   and one WIDTH-bit operand a, recovers the other operand b = sum - a.

---
 rtl/adder_sum_decomposer_if.sv | 24 ++
 rtl/adder_sum_decomposer.sv | 102 ++++++++++
 tb/tb_adder_sum_decomposer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_sum_decomposer_if.sv
// Handshake bundle for the serial sum decomposer: operation in (sum, a),
// result out (b, err), each with its own valid/ready pair.
interface adder_sum_decomposer_if #(
   parameter int WIDTH = 138
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] a;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] b;
   logic             err;

   modport master (
      output in_valid, sum, a, out_ready,
      input  in_ready, out_valid, b, err
   );

   modport slave (
      input  in_valid, sum, a, out_ready,
      output in_ready, out_valid, b, err
   );
endinterface

// File: rtl/adder_sum_decomposer.sv
// Recovers b = sum - a by subtracting CHUNK-bit slices one per cycle with a
// registered borrow; err flags results that do not fit in WIDTH bits.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operation
// RUN    | subtracting slice idx, one slice per cycle
// DONE   | out_valid high, b/err held until out_ready
module adder_sum_decomposer #(
   parameter int WIDTH = 138,
   parameter int CHUNK = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   adder_sum_decomposer_if.slave   bus
);
   localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;
   localparam int PW     = NCHUNK * CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [PW-1:0]    sum_q;
   logic [PW-1:0]    a_q;
   logic [PW-1:0]    diff_q;
   logic             borrow_q;
   logic [IW-1:0]    idx_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] b_q;
   logic             err_q;

   logic [CHUNK-1:0] sum_sl;
   logic [CHUNK-1:0] a_sl;
   logic [CHUNK:0]   sub;
   logic [PW-1:0]    diff_d;

   // One extra bit on the slice difference captures the borrow-out.
   always_comb begin
      sum_sl = sum_q[int'(idx_q)*CHUNK +: CHUNK];
      a_sl   = a_q[int'(idx_q)*CHUNK +: CHUNK];
      sub    = {1'b0, sum_sl} - {1'b0, a_sl} - {{CHUNK{1'b0}}, borrow_q};
      diff_d = diff_q;
      diff_d[int'(idx_q)*CHUNK +: CHUNK] = sub[CHUNK-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sum_q       <= '0;
         a_q         <= '0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         b_q         <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  sum_q      <= PW'(bus.sum);
                  a_q        <= PW'(bus.a);
                  diff_q     <= '0;
                  borrow_q   <= 1'b0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               diff_q   <= diff_d;
               borrow_q <= sub[CHUNK];
               if (idx_q == LAST) begin
                  idx_q       <= '0;
                  b_q         <= diff_d[WIDTH-1:0];
                  err_q       <= sub[CHUNK] | diff_d[WIDTH];
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.b         = b_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_adder_sum_decomposer.sv
// Directed and random checks of the serial sum decomposer at CHUNK = 32, 1 and 139.
module tb_adder_sum_decomposer;
   localparam int W = 138;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   adder_sum_decomposer_if #(.WIDTH(W)) bus0 ();
   adder_sum_decomposer_if #(.WIDTH(W)) bus1 ();
   adder_sum_decomposer_if #(.WIDTH(W)) bus2 ();

   adder_sum_decomposer #(.WIDTH(W), .CHUNK(32))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
   adder_sum_decomposer #(.WIDTH(W), .CHUNK(1))   dut1 (.clk(clk), .rst(rst), .bus(bus1));
   adder_sum_decomposer #(.WIDTH(W), .CHUNK(139)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_in(input int sel, input logic v, input logic [W:0] s, input logic [W-1:0] av);
      case (sel)
         0: begin bus0.in_valid = v; bus0.sum = s; bus0.a = av; end
         1: begin bus1.in_valid = v; bus1.sum = s; bus1.a = av; end
         default: begin bus2.in_valid = v; bus2.sum = s; bus2.a = av; end
      endcase
   endtask

   function automatic logic get_ov(input int sel);
      return (sel == 0) ? bus0.out_valid : (sel == 1) ? bus1.out_valid : bus2.out_valid;
   endfunction

   function automatic logic get_ir(input int sel);
      return (sel == 0) ? bus0.in_ready : (sel == 1) ? bus1.in_ready : bus2.in_ready;
   endfunction

   function automatic logic get_err(input int sel);
      return (sel == 0) ? bus0.err : (sel == 1) ? bus1.err : bus2.err;
   endfunction

   function automatic logic [W-1:0] get_b(input int sel);
      return (sel == 0) ? bus0.b : (sel == 1) ? bus1.b : bus2.b;
   endfunction

   function automatic logic [W-1:0] rnd138();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   // Starts at a negedge with the DUT idle and out_ready high; returns the
   // result, edges from acceptance to out_valid, and total cycles back to idle.
   task automatic run_op(input int sel, input logic [W:0] s, input logic [W-1:0] av,
                         output logic [W-1:0] ob, output logic oerr,
                         output int lat, output int cyc, output logic ir_after);
      int n;
      drive_in(sel, 1'b1, s, av);
      @(negedge clk);
      drive_in(sel, 1'b0, '0, '0);
      n = 1;
      while (!get_ov(sel) && n < 400) begin
         @(negedge clk);
         n++;
      end
      lat  = n;
      ob   = get_b(sel);
      oerr = get_err(sel);
      @(negedge clk);
      cyc      = n + 1;
      ir_after = get_ir(sel);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus0.in_ready); end
      n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus0.out_valid); end
      n_cmp++; if (bus0.b !== '0) begin n_fail++; $display("FAIL reset_b got %h want 0", bus0.b); end
      n_cmp++; if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus0.err); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if ({bus1.in_ready, bus2.in_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready_variants got %b want 11", {bus1.in_ready, bus2.in_ready}); end
   endtask

   task automatic test_basic();
      logic [W-1:0] ob; logic oerr; int lat; int cyc; logic ir;
      run_op(0, 139'd1000, 138'd300, ob, oerr, lat, cyc, ir);
      n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL basic_latency got %0d want 6", lat); end
      n_cmp++; if (ob !== 138'd700) begin n_fail++; $display("FAIL basic_b got %0d want 700", ob); end
      n_cmp++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", oerr); end
      n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_after got %b want 1", ir); end
   endtask

   task automatic test_borrow_ripple();
      logic [W-1:0] ob; logic oerr; int lat; int cyc; logic ir;
      logic [W:0] s;
      s = 139'd1 << 32;
      run_op(0, s, 138'd1, ob, oerr, lat, cyc, ir);
      n_cmp++; if (ob !== 138'hFFFF_FFFF) begin n_fail++; $display("FAIL ripple_b got %h want ffffffff", ob); end
      n_cmp++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL ripple_err got %b want 0", oerr); end
   endtask

   task automatic test_underflow();
      logic [W-1:0] ob; logic oerr; int lat; int cyc; logic ir;
      logic [W:0] s;
      int exp_lat [3];
      exp_lat = '{6, 140, 2};
      for (int sel = 0; sel < 3; sel++) begin
         run_op(sel, 139'd0, 138'd1, ob, oerr, lat, cyc, ir);
         n_cmp++; if (ob !== {W{1'b1}}) begin n_fail++; $display("FAIL underflow_b[%0d] got %h want all ones", sel, ob); end
         n_cmp++; if (oerr !== 1'b1) begin n_fail++; $display("FAIL underflow_err[%0d] got %b want 1", sel, oerr); end
         n_cmp++; if (lat !== exp_lat[sel]) begin n_fail++; $display("FAIL underflow_latency[%0d] got %0d want %0d", sel, lat, exp_lat[sel]); end
         s = (139'd1 << 138) + 139'd5;
         run_op(sel, s, 138'd5, ob, oerr, lat, cyc, ir);
         n_cmp++; if (ob !== '0) begin n_fail++; $display("FAIL overflow_b[%0d] got %h want 0", sel, ob); end
         n_cmp++; if (oerr !== 1'b1) begin n_fail++; $display("FAIL overflow_err[%0d] got %b want 1", sel, oerr); end
      end
   endtask

   task automatic test_backpressure();
      int n;
      bus0.out_ready = 1'b0;
      drive_in(0, 1'b1, 139'd123456789, 138'd23456789);
      @(negedge clk);
      drive_in(0, 1'b0, '0, '0);
      n = 1;
      while (!bus0.out_valid && n < 400) begin @(negedge clk); n++; end
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid[%0d] got %b want 1", i, bus0.out_valid); end
         n_cmp++; if (bus0.b !== 138'd100000000) begin n_fail++; $display("FAIL hold_b[%0d] got %0d want 100000000", i, bus0.b); end
         n_cmp++; if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL hold_err[%0d] got %b want 0", i, bus0.err); end
         n_cmp++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, bus0.in_ready); end
         drive_in(0, i[0], 139'd55, 138'd11);
         @(negedge clk);
      end
      drive_in(0, 1'b0, '0, '0);
      bus0.out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", bus0.in_ready); end
      n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got %b want 0", bus0.out_valid); end
      @(negedge clk);
      n_cmp++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL no_queued_op got in_ready %b want 1", bus0.in_ready); end
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] ob; logic oerr; int lat; int cyc; logic ir;
      drive_in(0, 1'b1, 139'd1000, 138'd1);
      @(negedge clk);
      drive_in(0, 1'b0, '0, '0);
      repeat (2) @(negedge clk);
      n_cmp++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_running got in_ready %b want 0", bus0.in_ready); end
      rst = 1'b1;
      #1;
      n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid got %b want 0", bus0.out_valid); end
      n_cmp++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got %b want 1", bus0.in_ready); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(0, 139'd7, 138'd7, ob, oerr, lat, cyc, ir);
      n_cmp++; if (ob !== '0) begin n_fail++; $display("FAIL equal_b got %h want 0", ob); end
      n_cmp++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL equal_err got %b want 0", oerr); end
      n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL equal_latency got %0d want 6", lat); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ob; logic oerr; int lat; int cyc; logic ir;
      logic [W-1:0] ra, rb;
      logic [W:0] s;
      int exp_cyc [3];
      int nops [3];
      exp_cyc = '{7, 141, 3};
      nops    = '{5, 2, 5};
      for (int sel = 0; sel < 3; sel++) begin
         for (int k = 0; k < nops[sel]; k++) begin
            ra = rnd138();
            rb = rnd138();
            s  = {1'b0, ra} + {1'b0, rb};
            run_op(sel, s, ra, ob, oerr, lat, cyc, ir);
            n_cmp++; if (ob !== rb) begin n_fail++; $display("FAIL b2b_b[%0d.%0d] got %h want %h", sel, k, ob, rb); end
            n_cmp++; if (oerr !== 1'b0) begin n_fail++; $display("FAIL b2b_err[%0d.%0d] got %b want 0", sel, k, oerr); end
            n_cmp++; if (cyc !== exp_cyc[sel]) begin n_fail++; $display("FAIL b2b_cycles[%0d.%0d] got %0d want %0d", sel, k, cyc, exp_cyc[sel]); end
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      for (int sel = 0; sel < 3; sel++) drive_in(sel, 1'b0, '0, '0);
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b1;
      bus2.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_borrow_ripple();
      test_underflow();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
